// File: rtl/red_seq_unit.sv
// Multi-cycle nibble reduction for the Execute stage: sums the eight signed
// 4-bit nibbles of rs and rt, one nibble pair per clock, with start/busy/done.
//
//   state | meaning
//   IDLE  | waiting for start; result holds last committed sum
//   ACC   | accumulating one nibble pair per edge (busy=1)
//   DONE  | result just committed; done=1 for this one cycle
module red_seq_unit #(
    parameter int WIDTH = 16,
    parameter int NIB   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    // Eight nibbles in -8..+7 sum to -64..+56, which fits 7 signed bits.
    localparam int ACC_W = 7;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ACC  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   rs_q, rs_d;
    logic [WIDTH-1:0]   rt_q, rt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic [NIB-1:0]     nib_a;
    logic [NIB-1:0]     nib_b;
    logic [ACC_W-1:0]   pair_sum;

    always_comb begin
        nib_a = '0;
        nib_b = '0;
        case (cnt_q)
            2'd0: begin
                nib_a = rs_q[NIB-1:0];
                nib_b = rt_q[NIB-1:0];
            end
            2'd1: begin
                nib_a = rs_q[2*NIB-1:NIB];
                nib_b = rt_q[2*NIB-1:NIB];
            end
            2'd2: begin
                nib_a = rs_q[3*NIB-1:2*NIB];
                nib_b = rt_q[3*NIB-1:2*NIB];
            end
            default: begin
                nib_a = rs_q[4*NIB-1:3*NIB];
                nib_b = rt_q[4*NIB-1:3*NIB];
            end
        endcase
        pair_sum = {{(ACC_W-NIB){nib_a[NIB-1]}}, nib_a}
                 + {{(ACC_W-NIB){nib_b[NIB-1]}}, nib_b};
    end

    always_comb begin
        state_d  = state_q;
        rs_d     = rs_q;
        rt_d     = rt_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        if (flush) begin
            // Squash wins over start and completion; result is left untouched.
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rs_d    = rs;
                        rt_d    = rt;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = ACC;
                    end
                end
                ACC: begin
                    acc_d = acc_q + pair_sum;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        result_d = {{(WIDTH-ACC_W){acc_d[ACC_W-1]}}, acc_d};
                        state_d  = DONE;
                    end
                end
                DONE: begin
                    if (start) begin
                        rs_d    = rs;
                        rt_d    = rt;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = ACC;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rs_q     <= '0;
            rt_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // Status decodes straight from state so reset clears them without a clock.
    assign busy   = (state_q == ACC);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule
